// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: funct3 codes, FSM states,
// lane count and the access-legality check.
package lsu_pkg;

    localparam int unsigned LSU_DATA_W = 32;
    localparam int unsigned LSU_LANES  = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_RESP   = 2'b10
    } lsu_state_t;

    // Misaligned half/word, reserved funct3, or an unsigned-width store.
    function automatic logic lsu_illegal(input logic       we,
                                         input logic [2:0] f3,
                                         input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = off[0];
            F3_W:        bad = (off != 2'b00);
            default:     bad = 1'b1;
        endcase
        if (we && f3[2]) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
//   rdata  : raw word from memory
//   offset : byte offset within the word (addr[1:0])
//   funct3 : access size / signedness
//   dout   : extended result
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] dout
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = 8'(rdata >> {offset, 3'b000});
    assign w_half = 16'(rdata >> {offset[1], 4'b0000});

    always_comb begin
        dout = rdata;
        case (funct3)
            F3_B:    dout = {{24{w_byte[7]}}, w_byte};
            F3_BU:   dout = {24'h000000, w_byte};
            F3_H:    dout = {{16{w_half[15]}}, w_half};
            F3_HU:   dout = {16'h0000, w_half};
            default: dout = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_ctrl.sv
// Data-memory sequencer: accepts one load/store at a time, runs a req/ack
// transaction, and returns extended load data or an error response.
//   clk/rst          : clock, synchronous active-high reset
//   req_*            : request from execute stage (valid/ready handshake)
//   mem_*            : data-memory port (registered outputs, held until ack)
//   resp_*           : one-cycle completion pulse with data and error flag
module load_store_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    lsu_state_t            r_state;
    lsu_state_t            w_state_nxt;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_req_err;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_ext;

    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [1:0]            r_off;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [3:0]            r_mem_be;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_resp_err;

    assign w_req_err = lsu_illegal(req_we, req_funct3, req_addr[1:0]);

    // Next state and handshake events.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_req_err ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Byte enables and lane-replicated store data; loads read the full word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = '0;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << req_addr[1:0];
                    w_wdata = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << req_addr[1:0];
                    w_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = req_wdata;
                end
            endcase
        end
    end

    load_extend u_load_extend (
        .rdata  (mem_rdata),
        .offset (r_off),
        .funct3 (r_funct3),
        .dout   (w_ext)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_off        <= 2'b00;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= 4'b0000;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_resp_valid <= 1'b0;
            if (w_accept) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_off    <= req_addr[1:0];
                if (w_req_err) begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b1;
                    r_resp_rdata <= '0;
                end else begin
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= req_we;
                    r_mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    r_mem_be    <= w_be;
                    r_mem_wdata <= w_wdata;
                end
            end
            if (w_done) begin
                r_mem_req    <= 1'b0;
                r_mem_we     <= 1'b0;
                r_mem_addr   <= '0;
                r_mem_be     <= 4'b0000;
                r_mem_wdata  <= '0;
                r_resp_valid <= 1'b1;
                r_resp_err   <= 1'b0;
                r_resp_rdata <= r_we ? '0 : w_ext;
            end
        end
    end

    // Ready is a state decode, held low while reset is asserted.
    assign req_ready  = (r_state == S_IDLE) && !rst;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_be     = r_mem_be;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Self-checking bench for load_store_ctrl: table of directed transactions
// plus a hand-written reset-during-access sequence.
module tb_load_store_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_resp  = 0;

    always #5 clk = ~clk;

    load_store_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always @(negedge clk) begin
        if (resp_valid === 1'b1) n_resp++;
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        logic        err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drives one request at a negedge and follows it to completion.
    task automatic run(input vec_t v, input string id);
        chk($sformatf("%s_ready", id), 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 32'h5A5A_0F0F;
        if (v.err) begin
            chk($sformatf("%s_rv", id), 32'(resp_valid), 32'd1);
            chk($sformatf("%s_err", id), 32'(resp_err), 32'd1);
            chk($sformatf("%s_rdata", id), resp_rdata, 32'h0);
            chk($sformatf("%s_mreq", id), 32'(mem_req), 32'd0);
            @(negedge clk);
            chk($sformatf("%s_rv_off", id), 32'(resp_valid), 32'd0);
            chk($sformatf("%s_mreq2", id), 32'(mem_req), 32'd0);
            chk($sformatf("%s_ready2", id), 32'(req_ready), 32'd1);
        end else begin
            for (int c = 0; c <= v.dly; c++) begin
                chk($sformatf("%s_c%0d_mreq", id, c), 32'(mem_req), 32'd1);
                chk($sformatf("%s_c%0d_we", id, c), 32'(mem_we), 32'(v.we));
                chk($sformatf("%s_c%0d_addr", id, c), mem_addr, v.exp_addr);
                chk($sformatf("%s_c%0d_be", id, c), 32'(mem_be), 32'(v.exp_be));
                chk($sformatf("%s_c%0d_wdata", id, c), mem_wdata, v.exp_wdata);
                chk($sformatf("%s_c%0d_rv", id, c), 32'(resp_valid), 32'd0);
                if (c == v.dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                    req_valid = 1'b0;
                end else begin
                    // Stray requests while busy must be ignored.
                    mem_ack    = 1'b0;
                    mem_rdata  = 32'hFFFF_FFFF;
                    req_valid  = (c % 2 == 0);
                    req_we     = ~v.we;
                    req_funct3 = F3_W;
                    req_addr   = 32'h0000_0ABC;
                end
                @(negedge clk);
            end
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            req_valid = 1'b0;
            chk($sformatf("%s_rv", id), 32'(resp_valid), 32'd1);
            chk($sformatf("%s_err", id), 32'(resp_err), 32'd0);
            chk($sformatf("%s_rdata", id), resp_rdata, v.exp_rdata);
            chk($sformatf("%s_mreq_off", id), 32'(mem_req), 32'd0);
            chk($sformatf("%s_ready_resp", id), 32'(req_ready), 32'd0);
            @(negedge clk);
            chk($sformatf("%s_rv_off", id), 32'(resp_valid), 32'd0);
            chk($sformatf("%s_ready2", id), 32'(req_ready), 32'd1);
            chk($sformatf("%s_hold", id), resp_rdata, v.exp_rdata);
        end
    endtask

    initial begin
        vec_t lw300;

        //          we    f3     addr          wdata         rdata         dly err  exp_addr      be       exp_wdata     exp_rdata
        vecs[0]  = '{1'b0, F3_B,  32'h0000_0103, 32'h0,        32'h80AB_CDEF, 0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_FF80};
        vecs[1]  = '{1'b0, F3_BU, 32'h0000_0102, 32'h0,        32'h8F12_3456, 0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_0012};
        vecs[2]  = '{1'b0, F3_HU, 32'h0000_0102, 32'h0,        32'h8F12_3456, 1, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_8F12};
        vecs[3]  = '{1'b0, F3_H,  32'h0000_0102, 32'h0,        32'h8F12_3456, 0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_8F12};
        vecs[4]  = '{1'b1, F3_B,  32'h0000_0201, 32'h1234_56A5, 32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0200, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vecs[5]  = '{1'b1, F3_H,  32'h0000_0202, 32'h1234_56A5, 32'hDEAD_BEEF, 1, 1'b0, 32'h0000_0200, 4'b1100, 32'h56A5_56A5, 32'h0};
        vecs[6]  = '{1'b0, F3_W,  32'h0000_0008, 32'h0,        32'h1357_9BDF, 2, 1'b0, 32'h0000_0008, 4'b1111, 32'h0,        32'h1357_9BDF};
        vecs[7]  = '{1'b0, F3_W,  32'h0000_0006, 32'h0,        32'h0,         0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0};
        vecs[8]  = '{1'b0, F3_B,  32'h0000_0100, 32'h0,        32'h0000_007F, 0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_007F};
        vecs[9]  = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,       32'h0,         0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0};
        vecs[10] = '{1'b1, F3_W,  32'h0000_0304, 32'hCAFE_F00D, 32'h1111_2222, 5, 1'b0, 32'h0000_0304, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[11] = '{1'b0, F3_H,  32'h0000_0100, 32'h0,        32'h1234_8001, 0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_8001};
        vecs[12] = '{1'b1, F3_BU, 32'h0000_0100, 32'h0000_00FF, 32'h0,        0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0};
        vecs[13] = '{1'b0, F3_BU, 32'h0000_0101, 32'h0,        32'h0000_C3F0, 0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_00C3};
        vecs[14] = '{1'b0, F3_HU, 32'h0000_0001, 32'h0,        32'h0,         0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0};
        lw300    = '{1'b0, F3_W,  32'h0000_0300, 32'h0,        32'h0BAD_F00D, 1, 1'b0, 32'h0000_0300, 4'b1111, 32'h0,        32'h0BAD_F00D};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_mreq", 32'(mem_req), 32'd0);
        chk("rst_mwe", 32'(mem_we), 32'd0);
        chk("rst_maddr", mem_addr, 32'h0);
        chk("rst_mwdata", mem_wdata, 32'h0);
        chk("rst_mbe", 32'(mem_be), 32'd0);
        chk("rst_rv", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        #1;

        for (int i = 0; i < NVEC; i++) begin
            run(vecs[i], $sformatf("v%0d", i));
        end

        // Reset lands in the second ACCESS cycle; the ack that follows is stale.
        chk("rs_ready", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F3_W;
        req_addr   = 32'h0000_0400;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rs_mreq1", 32'(mem_req), 32'd1);
        @(negedge clk);
        chk("rs_mreq2", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_mreq_rst", 32'(mem_req), 32'd0);
        chk("rs_maddr_rst", mem_addr, 32'h0);
        chk("rs_rv_rst", 32'(resp_valid), 32'd0);
        chk("rs_ready_rst", 32'(req_ready), 32'd0);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        #1;
        chk("rs_ready_after", 32'(req_ready), 32'd1);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rs_rv_late_ack", 32'(resp_valid), 32'd0);
        chk("rs_mreq_late_ack", 32'(mem_req), 32'd0);
        chk("rs_ready_idle", 32'(req_ready), 32'd1);

        run(lw300, "lw300");

        repeat (2) @(negedge clk);
        chk("resp_pulse_count", 32'(n_resp), 32'(NVEC + 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_ctrl.md
# load_store_ctrl

Sequencing controller for the data-memory path of the RISC-V core: accepts one load/store request at a time from the execute stage, runs a req/ack transaction on the data-memory port, and returns a sign- or zero-extended load result. It owns byte-lane selection, byte enables and store-data replication for LB/LH/LW/LBU/LHU/SB/SH/SW, and detects misaligned or illegal accesses before any memory traffic.

## Interface
- DATA_WIDTH, 32: data word width (fixed at 32; byte lanes = 4)
- ADDR_WIDTH, 32: byte address width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle and can accept
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- mem_req  out  1  memory transaction active
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  word-aligned address, low 2 bits = 0
- mem_wdata  out  DATA_WIDTH  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  memory completes transaction this cycle
- mem_rdata  in  DATA_WIDTH  read word, valid when mem_ack = 1
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal request; qualified by resp_valid

## Operation
- FSM: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: req_ready = 1. Accept when req_valid = 1; latch we, funct3, addr[1:0], wdata.
- Error check at accept: H/HU with addr[0] = 1; W with addr[1:0] != 0; funct3 in {011, 110, 111}; store with funct3[2] = 1. Error -> RESP with resp_err = 1, mem_req never asserted.
- Legal -> ACCESS. mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
- Store: SB mem_be = 0001 << addr[1:0], mem_wdata = {4{wdata[7:0]}}; SH mem_be = 0011 << addr[1:0], mem_wdata = {2{wdata[15:0]}}; SW mem_be = 1111, mem_wdata = wdata.
- Load: mem_we = 0, mem_be = 1111, mem_wdata = 0.
- ACCESS: mem_req held at 1, all mem_* held stable until mem_ack = 1; then -> RESP.
- Load extraction on ack: byte = mem_rdata[8*addr[1:0] +: 8], half = mem_rdata[16*addr[1] +: 16]; B/H sign-extend bit 7/15, BU/HU zero-extend, W passthrough. Result registered into resp_rdata.
- RESP: resp_valid = 1 for exactly one cycle, req_ready = 0; -> IDLE. resp_rdata/resp_err hold until next RESP.
- mem_ack outside ACCESS ignored. req_valid outside IDLE ignored (requester must hold until accepted).

## Timing
- Reset values: mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_be 0, resp_valid 0, resp_rdata 0, resp_err 0; req_ready 0 while rst = 1, 1 in the first cycle after.
- Accept edge T -> mem_req = 1 in cycle T+1. Ack sampled at edge T+k (k >= 1) -> mem_req = 0 and resp_valid = 1 in cycle T+k+1 -> req_ready = 1 in T+k+2. Minimum legal latency accept-to-resp_valid: 2 cycles; throughput at most one request per 3 cycles.
- Error path: resp_valid = 1 in cycle T+1.
- mem_req, mem_we, mem_be, mem_addr, mem_wdata are registered; req_ready is a decode of state (forced 0 during rst).
- rst mid-ACCESS: at the reset edge all outputs return to reset values, transaction abandoned, no resp_valid; a late mem_ack is ignored.

## Structure
- Package lsu_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum lsu_state_t, byte-lane count 4.
- Sub-module load_extend: combinational lane select + sign/zero extend; inputs rdata[31:0], offset[1:0], funct3[2:0]; output dout[31:0]. Instantiated once, feeding the resp_rdata register.

## Test plan
- LB addr 0x103, mem_rdata 0x80AB_CDEF, ack after 1 cycle -> mem_addr 0x100, mem_be 1111, resp_rdata 0xFFFF_FF80 at accept+2.
- LBU then LHU addr 0x102, mem_rdata 0x8F12_3456 -> 0x0000_0012, then 0x0000_8F12; LH same -> 0xFFFF_8F12.
- SB addr 0x201 wdata 0x1234_56A5 -> mem_we 1, mem_be 0010, mem_wdata 0xA5A5_A5A5; SH addr 0x202 -> mem_be 1100, mem_wdata 0x56A5_56A5.
- LW addr 0x006 -> resp_valid, resp_err 1 at accept+1, resp_rdata 0, mem_req never 1; funct3 011 -> same.
- Ack delayed 5 cycles -> mem_* stable for 6 cycles, req_valid pulses meanwhile ignored, single resp_valid.
- rst asserted in 2nd ACCESS cycle, ack arriving 1 cycle later -> no resp_valid, mem_req 0, req_ready 1 after rst deasserts; next LW 0x300 completes normally.
